battle_sprite_sequencer: RTL and testbench
==========================================

Name: battle_sprite_sequencer

Overview:
Sequences the battle-scene sprite renderers by driving their x/y origin inputs frame by frame: slide-in intro, hold, active battle, and slide-out exit. Positions update once per frame, during vertical blanking, so sprites never tear. It sits between the game-state FSM (start/exit handshake) and the back/front sprite renderers, all on the pixel clock.

Parameters:
STEP, 4, pixels moved per frame during slides
PLAYER_START_X, 0, player (back) sprite x when off-stage
PLAYER_END_X, 64, player sprite x when on-stage (must be > PLAYER_START_X)
ENEMY_START_X, 864, enemy (front) sprite x when off-stage
ENEMY_END_X, 800, enemy sprite x when on-stage (must be < ENEMY_START_X)
PLAYER_Y, 500, fixed player sprite y
ENEMY_Y, 100, fixed enemy sprite y
HOLD_FRAMES, 30, frames spent in HOLD
FRAME_LINE, 768, vcount_in value that marks the frame tick (first blanking line)

Ports:
pixel_clk_in  in  1  pixel clock, sole clock
rst_in  in  1  asynchronous, active-high reset
hcount_in  in  11  current pixel column
vcount_in  in  10  current pixel row
start_in  in  1  level; begin intro when IDLE
exit_in  in  1  single-cycle pulse; request slide-out
player_x_out  out  11  player sprite x origin
player_y_out  out  10  player sprite y origin (constant PLAYER_Y)
enemy_x_out  out  11  enemy sprite x origin
enemy_y_out  out  10  enemy sprite y origin (constant ENEMY_Y)
visible_out  out  1  renderers enabled
busy_out  out  1  animation in progress
done_out  out  1  one-cycle completion pulse
phase_out  out  3  current state encoding

Behaviour:
- Reset (asynchronous): player_x_out=PLAYER_START_X, enemy_x_out=ENEMY_START_X, visible_out=0, busy_out=0, done_out=0, phase_out=0. Frame counter and exit_pending clear. The y outputs are always constant.
- Frame tick: match = (hcount_in==0 && vcount_in==FRAME_LINE), registered; tick = match_q & ~match_q2. Exactly one pulse per frame.
- Latency: x outputs change at the clock edge where tick is high, which is 2 edges after the match cycle is sampled.
- State encoding on phase_out: IDLE=0, SLIDE_IN=1, HOLD=2, ACTIVE=3, SLIDE_OUT=4.
- IDLE: start_in=1 moves to SLIDE_IN on the next edge. exit_in is ignored in IDLE.
- SLIDE_IN, on each tick:
  - player_x += STEP, snapping to PLAYER_END_X if the remaining distance is < STEP.
  - enemy_x -= STEP, snapping to ENEMY_END_X likewise.
  - When both are at their end positions after the update, go to HOLD with the frame counter cleared.
- HOLD: the counter increments per tick. On the tick where counter==HOLD_FRAMES-1, go to ACTIVE and pulse done_out for 1 cycle.
- exit_in during SLIDE_IN or HOLD sets exit_pending. ACTIVE with exit_pending set goes to SLIDE_OUT on the next edge and clears exit_pending.
- ACTIVE: exit_in goes to SLIDE_OUT on the next edge.
- SLIDE_OUT, on each tick: movement is mirrored back toward the start positions with the same snapping. When both are home, go to IDLE and pulse done_out for 1 cycle.
- Repeated start_in or exit_in while already in SLIDE_OUT is ignored.
- Arithmetic is unsigned 11-bit. Snap comparisons use distance, never a wrapped sum, so there is no overflow past 2047.
- visible_out=1 in every state except IDLE. busy_out=1 in SLIDE_IN, HOLD and SLIDE_OUT.
- A tick and a state change in the same cycle: the move is applied using the current state, and the transition takes effect for the next tick.

Optional Feature:
BATTLE_SEQ_SHAKE_EN
- Defined:
  - Adds port shake_in (in, 1, pulse) and parameters SHAKE_AMP=2 and SHAKE_FRAMES=8.
  - shake_in in ACTIVE starts a shake: on successive ticks enemy_x_out alternates ENEMY_END_X+SHAKE_AMP and ENEMY_END_X-SHAKE_AMP for SHAKE_FRAMES ticks, then returns to ENEMY_END_X.
  - A shake_in during an active shake restarts the count.
  - exit_in during a shake aborts it, restores ENEMY_END_X, and enters SLIDE_OUT.
- Undefined: no port, and enemy_x_out is static in ACTIVE.

Decomposition:
- Package battle_seq_pkg:
  - state enum typedef (3-bit, with the values above)
  - coordinate typedefs xcoord_t (11-bit) and ycoord_t (10-bit)
- Sub-module battle_frame_tick: hcount/vcount compare, register, and edge-detect producing the tick. Parameter FRAME_LINE. Reused by future animation blocks.

Test Plan:
- Reset mid-SLIDE_IN (player_x=32) -> player_x_out=0, enemy_x_out=864, phase_out=0, visible_out=0 immediately (asynchronous, no clock edge needed).
- start_in pulse, then 16 frames -> player_x_out steps 0,4,…,64 and enemy_x_out steps 864,…,800, one step per frame, each change 2 edges after the match. Then phase_out=2.
- 30 HOLD ticks -> phase_out=3, done_out high for exactly 1 cycle, busy_out=0.
- exit_in during HOLD frame 10 -> HOLD still runs to completion, done_out pulses, then SLIDE_OUT begins the next cycle. After 16 frames: IDLE, done_out pulse, visible_out=0.
- Snap case with STEP=5 -> player_x sequence ends …,60,64 and enemy_x ends …,804,800. No overshoot.
- Macro defined: shake_in in ACTIVE -> enemy_x_out goes 802,798,… for 8 frames, then 800. exit_in at shake frame 3 -> enemy_x_out=800 and SLIDE_OUT starts.

Source files
------------

// File: rtl/battle_seq_pkg.sv
// Shared types and helpers for the battle sprite sequencer.
// Holds the phase encoding that the game-state FSM sees on phase_out,
// the coordinate types and the snapping step helpers used by the
// slide animations.
package battle_seq_pkg;

    // Phase encoding presented on phase_out.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SLIDE_IN  = 3'd1,
        ST_HOLD      = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_SLIDE_OUT = 3'd4
    } seq_state_t;

    typedef logic [10:0] xcoord_t;
    typedef logic [9:0]  ycoord_t;

    // Move cur upward by step toward target. Compares the remaining distance
    // rather than cur+step so a position near 2047 can never wrap.
    function automatic xcoord_t step_up(input xcoord_t cur,
                                        input xcoord_t target,
                                        input xcoord_t step);
        xcoord_t res;
        if (cur >= target) begin
            res = target;
        end else if ((target - cur) < step) begin
            res = target;
        end else begin
            res = cur + step;
        end
        return res;
    endfunction

    // Move cur downward by step toward target, landing exactly on target
    // when closer than one step. Never underflows below target.
    function automatic xcoord_t step_down(input xcoord_t cur,
                                          input xcoord_t target,
                                          input xcoord_t step);
        xcoord_t res;
        if (cur <= target) begin
            res = target;
        end else if ((cur - target) < step) begin
            res = target;
        end else begin
            res = cur - step;
        end
        return res;
    endfunction

endpackage

// File: rtl/battle_frame_tick.sv
// Frame tick generator: flags the first pixel of the first blanking line
// and turns it into exactly one single-cycle pulse per frame, even if the
// raster inputs dwell on that pixel for more than one clock.
module battle_frame_tick #(
    parameter int FRAME_LINE = 768
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic        tick_out
);

    localparam logic [9:0] LINE = 10'(FRAME_LINE);

    logic match_d;
    logic match_q;
    logic match_dly_q;

    assign match_d = (hcount_in == 11'd0) && (vcount_in == LINE);

    // Register the raster match and keep one cycle of history for edge detect.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            match_q     <= 1'b0;
            match_dly_q <= 1'b0;
        end else begin
            match_q     <= match_d;
            match_dly_q <= match_q;
        end
    end

    // Rising edge of the registered match is the frame tick.
    assign tick_out = match_q & ~match_dly_q;

endmodule

// File: rtl/battle_sprite_sequencer.sv
// Battle sprite sequencer: drives player/enemy sprite origins through
// intro slide, hold, active battle and exit slide. Positions only move on
// the frame tick (vertical blanking) so the renderers never tear.
// Optional screen-shake of the enemy sprite in ACTIVE is compiled in when
// the macro BATTLE_SEQ_SHAKE_EN is defined (adds shake_in, SHAKE_AMP and
// SHAKE_FRAMES).
module battle_sprite_sequencer
    import battle_seq_pkg::*;
#(
    parameter int STEP           = 4,
    parameter int PLAYER_START_X = 0,
    parameter int PLAYER_END_X   = 64,
    parameter int ENEMY_START_X  = 864,
    parameter int ENEMY_END_X    = 800,
    parameter int PLAYER_Y       = 500,
    parameter int ENEMY_Y        = 100,
    parameter int HOLD_FRAMES    = 30,
    parameter int FRAME_LINE     = 768
`ifdef BATTLE_SEQ_SHAKE_EN
    ,
    parameter int SHAKE_AMP      = 2,
    parameter int SHAKE_FRAMES   = 8
`endif
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        start_in,
    input  logic        exit_in,
`ifdef BATTLE_SEQ_SHAKE_EN
    input  logic        shake_in,
`endif
    output logic [10:0] player_x_out,
    output logic [9:0]  player_y_out,
    output logic [10:0] enemy_x_out,
    output logic [9:0]  enemy_y_out,
    output logic        visible_out,
    output logic        busy_out,
    output logic        done_out,
    output logic [2:0]  phase_out
);

    localparam xcoord_t STEP_X    = xcoord_t'(STEP);
    localparam xcoord_t P_START   = xcoord_t'(PLAYER_START_X);
    localparam xcoord_t P_END     = xcoord_t'(PLAYER_END_X);
    localparam xcoord_t E_START   = xcoord_t'(ENEMY_START_X);
    localparam xcoord_t E_END     = xcoord_t'(ENEMY_END_X);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);

`ifdef BATTLE_SEQ_SHAKE_EN
    localparam xcoord_t    SHAKE_HI = xcoord_t'(ENEMY_END_X + SHAKE_AMP);
    localparam xcoord_t    SHAKE_LO = xcoord_t'(ENEMY_END_X - SHAKE_AMP);
    localparam logic [7:0] SHAKE_N  = 8'(SHAKE_FRAMES);
`endif

    logic        tick;
    seq_state_t  state_q;
    xcoord_t     player_x_q;
    xcoord_t     enemy_x_q;
    logic [15:0] hold_cnt_q;
    logic        exit_pend_q;
    logic        done_q;
    logic        visible_q;
    logic        busy_q;

`ifdef BATTLE_SEQ_SHAKE_EN
    logic [7:0]  shake_left_q;
    logic        shake_neg_q;
`endif

    // Candidate positions for the next tick in each slide direction.
    xcoord_t player_in_d;
    xcoord_t enemy_in_d;
    xcoord_t player_out_d;
    xcoord_t enemy_out_d;

    assign player_in_d  = step_up(player_x_q, P_END, STEP_X);
    assign enemy_in_d   = step_down(enemy_x_q, E_END, STEP_X);
    assign player_out_d = step_down(player_x_q, P_START, STEP_X);
    assign enemy_out_d  = step_up(enemy_x_q, E_START, STEP_X);

    battle_frame_tick #(
        .FRAME_LINE (FRAME_LINE)
    ) u_frame_tick (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .tick_out     (tick)
    );

    // Sequencer FSM: phase, positions, hold counter, pending exit and the
    // registered status outputs all update together.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            player_x_q   <= P_START;
            enemy_x_q    <= E_START;
            hold_cnt_q   <= '0;
            exit_pend_q  <= 1'b0;
            done_q       <= 1'b0;
            visible_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef BATTLE_SEQ_SHAKE_EN
            shake_left_q <= '0;
            shake_neg_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        state_q   <= ST_SLIDE_IN;
                        visible_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end

                ST_SLIDE_IN: begin
                    if (exit_in) begin
                        exit_pend_q <= 1'b1;
                    end
                    if (tick) begin
                        player_x_q <= player_in_d;
                        enemy_x_q  <= enemy_in_d;
                        if ((player_in_d == P_END) && (enemy_in_d == E_END)) begin
                            state_q    <= ST_HOLD;
                            hold_cnt_q <= '0;
                        end
                    end
                end

                ST_HOLD: begin
                    if (exit_in) begin
                        exit_pend_q <= 1'b1;
                    end
                    if (tick) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_q <= ST_ACTIVE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 16'd1;
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (exit_in || exit_pend_q) begin
                        state_q     <= ST_SLIDE_OUT;
                        exit_pend_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef BATTLE_SEQ_SHAKE_EN
                        // Abort any shake so the exit slide starts from rest.
                        enemy_x_q    <= E_END;
                        shake_left_q <= '0;
                        shake_neg_q  <= 1'b0;
                    end else if (shake_in) begin
                        shake_left_q <= SHAKE_N;
                        shake_neg_q  <= 1'b0;
                    end else if (tick) begin
                        if (shake_left_q != 8'd0) begin
                            enemy_x_q    <= shake_neg_q ? SHAKE_LO : SHAKE_HI;
                            shake_neg_q  <= ~shake_neg_q;
                            shake_left_q <= shake_left_q - 8'd1;
                        end else begin
                            enemy_x_q <= E_END;
                        end
`endif
                    end
                end

                ST_SLIDE_OUT: begin
                    if (tick) begin
                        player_x_q <= player_out_d;
                        enemy_x_q  <= enemy_out_d;
                        if ((player_out_d == P_START) && (enemy_out_d == E_START)) begin
                            state_q   <= ST_IDLE;
                            done_q    <= 1'b1;
                            visible_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    visible_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign player_x_out = player_x_q;
    assign enemy_x_out  = enemy_x_q;
    assign player_y_out = ycoord_t'(PLAYER_Y);
    assign enemy_y_out  = ycoord_t'(ENEMY_Y);
    assign visible_out  = visible_q;
    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign phase_out    = state_q;

endmodule

// File: tb/tb_battle_sprite_sequencer.sv
// Bench for battle_sprite_sequencer: two instances (STEP=4 and STEP=5)
// share randomized raster/handshake stimulus; an expected snapshot per
// clock edge is queued from a frame-count reference model and a separate
// monitor pops and compares at the falling edge.
// Define BATTLE_SEQ_SHAKE_EN to exercise the shake feature as well.
module tb_battle_sprite_sequencer;

    localparam int FL = 768;
    localparam int HF = 30;
    localparam int PS = 0;
    localparam int PE = 64;
    localparam int ES = 864;
    localparam int EE = 800;
    localparam int PY = 500;
    localparam int EY = 100;
    localparam int SA = 2;
    localparam int SF = 8;
`ifdef BATTLE_SEQ_SHAKE_EN
    localparam bit SHK = 1'b1;
`else
    localparam bit SHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        start;
    logic        exit_p;
`ifdef BATTLE_SEQ_SHAKE_EN
    logic        shake;
`endif

    logic [10:0] a_px, a_ex, b_px, b_ex;
    logic [9:0]  a_py, a_ey, b_py, b_ey;
    logic        a_vis, a_busy, a_done, b_vis, b_busy, b_done;
    logic [2:0]  a_ph, b_ph;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    battle_sprite_sequencer u_dut_a (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .hcount_in    (hcount),
        .vcount_in    (vcount),
        .start_in     (start),
        .exit_in      (exit_p),
`ifdef BATTLE_SEQ_SHAKE_EN
        .shake_in     (shake),
`endif
        .player_x_out (a_px),
        .player_y_out (a_py),
        .enemy_x_out  (a_ex),
        .enemy_y_out  (a_ey),
        .visible_out  (a_vis),
        .busy_out     (a_busy),
        .done_out     (a_done),
        .phase_out    (a_ph)
    );

    battle_sprite_sequencer #(.STEP(5)) u_dut_b (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .hcount_in    (hcount),
        .vcount_in    (vcount),
        .start_in     (start),
        .exit_in      (exit_p),
`ifdef BATTLE_SEQ_SHAKE_EN
        .shake_in     (shake),
`endif
        .player_x_out (b_px),
        .player_y_out (b_py),
        .enemy_x_out  (b_ex),
        .enemy_y_out  (b_ey),
        .visible_out  (b_vis),
        .busy_out     (b_busy),
        .done_out     (b_done),
        .phase_out    (b_ph)
    );

    // Reference model: positions derive from the number of slide frames seen.
    typedef struct {
        int phase;
        int k;
        int hcnt;
        bit pend;
        int px;
        int ex;
        bit done;
        int sh_left;
        int sh_n;
    } model_t;

    typedef struct {
        int     due;
        model_t a;
        model_t b;
    } sb_t;

    sb_t    sb[$];
    model_t ma, mb;
    bit     mh1, mh2;
    int     checks = 0;
    int     errors = 0;

    function automatic model_t model_reset();
        model_t m;
        m.phase = 0; m.k = 0; m.hcnt = 0; m.pend = 1'b0;
        m.px = PS; m.ex = ES; m.done = 1'b0; m.sh_left = 0; m.sh_n = 0;
        return m;
    endfunction

    function automatic model_t model_edge(input model_t m, input int step,
                                          input bit tick, input bit st,
                                          input bit ex_in, input bit sh);
        model_t n;
        n = m;
        n.done = 1'b0;
        case (m.phase)
            0: if (st) begin n.phase = 1; n.k = 0; end
            1: begin
                if (ex_in) n.pend = 1'b1;
                if (tick) begin
                    n.k  = m.k + 1;
                    n.px = (PS + n.k * step > PE) ? PE : PS + n.k * step;
                    n.ex = (ES - n.k * step < EE) ? EE : ES - n.k * step;
                    if (n.px == PE && n.ex == EE) begin n.phase = 2; n.hcnt = 0; end
                end
            end
            2: begin
                if (ex_in) n.pend = 1'b1;
                if (tick) begin
                    n.hcnt = m.hcnt + 1;
                    if (n.hcnt == HF) begin n.phase = 3; n.done = 1'b1; end
                end
            end
            3: begin
                if (ex_in || m.pend) begin
                    n.phase = 4; n.pend = 1'b0; n.k = 0; n.ex = EE; n.sh_left = 0;
                end else if (sh) begin
                    n.sh_left = SF; n.sh_n = 0;
                end else if (tick) begin
                    if (m.sh_left > 0) begin
                        n.ex = (m.sh_n % 2 == 0) ? EE + SA : EE - SA;
                        n.sh_n = m.sh_n + 1;
                        n.sh_left = m.sh_left - 1;
                    end else begin
                        n.ex = EE;
                    end
                end
            end
            default: begin
                if (tick) begin
                    n.k  = m.k + 1;
                    n.px = (PE - n.k * step < PS) ? PS : PE - n.k * step;
                    n.ex = (EE + n.k * step > ES) ? ES : EE + n.k * step;
                    if (n.px == PS && n.ex == ES) begin n.phase = 0; n.done = 1'b1; end
                end
            end
        endcase
        return n;
    endfunction

    task automatic check_out(input string tag, input model_t m,
                             input logic [10:0] px, input logic [10:0] ex,
                             input logic [9:0] py, input logic [9:0] ey,
                             input logic [2:0] ph, input logic vis,
                             input logic bsy, input logic dn);
        logic e_vis, e_bsy;
        e_vis = (m.phase != 0);
        e_bsy = (m.phase == 1 || m.phase == 2 || m.phase == 4);
        checks++;
        if (px !== 11'(m.px) || ex !== 11'(m.ex) || py !== 10'(PY) || ey !== 10'(EY) ||
            ph !== 3'(m.phase) || vis !== e_vis || bsy !== e_bsy || dn !== m.done) begin
            errors++;
            $display("FAIL %s cyc=%0d got px=%0d ex=%0d py=%0d ey=%0d ph=%0d vis=%0b busy=%0b done=%0b want px=%0d ex=%0d py=%0d ey=%0d ph=%0d vis=%0b busy=%0b done=%0b",
                     tag, cyc, px, ex, py, ey, ph, vis, bsy, dn,
                     m.px, m.ex, PY, EY, m.phase, e_vis, e_bsy, m.done);
        end
    endtask

    // One clock of stimulus; queues the expected state after the coming edge.
    task automatic drive(input bit match, input bit st, input bit ex,
                         input bit sh, input bit r);
        sb_t e;
        bit  tk;
        @(posedge clk);
        #1;
        rst = r;
        if (match) begin
            hcount = 11'd0;
            vcount = 10'(FL);
        end else begin
            case ($urandom_range(0, 2))
                0: begin
                    hcount = 11'd0;
                    vcount = 10'($urandom_range(0, 767));
                end
                1: begin
                    hcount = 11'($urandom_range(1, 1343));
                    vcount = 10'(FL);
                end
                default: begin
                    hcount = 11'($urandom_range(1, 2047));
                    vcount = 10'($urandom_range(0, 1023));
                end
            endcase
        end
        start  = st;
        exit_p = ex;
`ifdef BATTLE_SEQ_SHAKE_EN
        shake  = sh;
`endif
        if (r) begin
            ma = model_reset();
            mb = model_reset();
            mh1 = 1'b0;
            mh2 = 1'b0;
        end else begin
            tk = mh1 && !mh2;
            ma = model_edge(ma, 4, tk, st, ex, sh);
            mb = model_edge(mb, 5, tk, st, ex, sh);
            mh2 = mh1;
            mh1 = match;
        end
        e.due = cyc + 1;
        e.a = ma;
        e.b = mb;
        sb.push_back(e);
    endtask

    // One frame: a match cycle (optionally held two clocks), then a random gap.
    task automatic frame(input bit st, input bit ex, input bit sh, input bit dbl);
        int gap;
        drive(1'b1, st, 1'b0, sh, 1'b0);
        if (dbl) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        gap = $urandom_range(2, 6);
        for (int i = 0; i < gap; i++) begin
            drive(1'b0, 1'b0, (i == 0) ? ex : 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Assert reset between edges and confirm the outputs clear with no edge.
    task automatic async_reset_check();
        model_t z;
        @(posedge clk);
        #3;
        sb.delete();
        rst = 1'b1;
        #1;
        z = model_reset();
        check_out("async_rst_a", z, a_px, a_ex, a_py, a_ey, a_ph, a_vis, a_busy, a_done);
        check_out("async_rst_b", z, b_px, b_ex, b_py, b_ey, b_ph, b_vis, b_busy, b_done);
        ma = z;
        mb = z;
        mh1 = 1'b0;
        mh2 = 1'b0;
    endtask

    // Monitor: compare every queued expectation at the falling edge it is due.
    initial begin
        sb_t e;
        int  last_px, last_ex, last_ph;
        last_px = -1; last_ex = -1; last_ph = -1;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_late due=%0d now=%0d", e.due, cyc);
                end else begin
                    check_out("out_a", e.a, a_px, a_ex, a_py, a_ey, a_ph, a_vis, a_busy, a_done);
                    check_out("out_b", e.b, b_px, b_ex, b_py, b_ey, b_ph, b_vis, b_busy, b_done);
                    if (e.a.px != last_px || e.a.ex != last_ex || e.a.phase != last_ph || e.a.done) begin
                        $display("tx cyc=%0d a: px=%0d ex=%0d ph=%0d done=%0b | b: px=%0d ex=%0d ph=%0d done=%0b",
                                 cyc, a_px, a_ex, a_ph, a_done, b_px, b_ex, b_ph, b_done);
                        last_px = e.a.px; last_ex = e.a.ex; last_ph = e.a.phase;
                    end
                end
            end
        end
    end

    initial begin
        bit exited;
        bit ex_now;
        rst = 1'b1; start = 1'b0; exit_p = 1'b0;
        hcount = 11'd1; vcount = 10'd0;
`ifdef BATTLE_SEQ_SHAKE_EN
        shake = 1'b0;
`endif
        ma = model_reset(); mb = model_reset();
        mh1 = 1'b0; mh2 = 1'b0;

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // IDLE: stray frame matches and exit pulses must change nothing.
        for (int i = 0; i < 24; i++) begin
            drive($urandom_range(0, 3) == 0, 1'b0, $urandom_range(0, 2) == 0, 1'b0, 1'b0);
        end

        // Partial intro (player at 32 on the STEP=4 unit), then async reset.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 8; f++) frame(1'b0, 1'b0, 1'b0, 1'b0);
        async_reset_check();
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full run with an exit request queued during HOLD.
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exited = 1'b0;
        for (int f = 0; f < 150 && !(ma.phase == 0 && mb.phase == 0); f++) begin
            ex_now = (!exited && ma.phase == 2 && ma.hcnt == 10);
            if (ex_now) exited = 1'b1;
            frame(1'b0, ex_now, 1'b0, (f % 7) == 3);
        end

        // Second run: reach ACTIVE, shake/restart, exit from ACTIVE,
        // then stray start/exit pulses during the exit slide.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 100 && !(ma.phase == 3 && mb.phase == 3); f++) begin
            frame(1'b0, 1'b0, 1'b0, f == 2);
        end
        for (int f = 0; f < 12; f++) begin
            frame(1'b0, 1'b0, SHK && (f == 0), 1'b0);
        end
        for (int f = 0; f < 9; f++) begin
            frame(1'b0, f == 8, SHK && (f == 0 || f == 5), 1'b0);
        end
        for (int f = 0; f < 100 && !(ma.phase == 0 && mb.phase == 0); f++) begin
            frame(f < 2, f < 2, 1'b0, 1'b0);
        end

        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain left=%0d want=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
